// File: rtl/mem_responder_if.sv
// mem_responder_if: bus between a requester and mem_responder.
// MEM_IO_PORT_EN adds the io_out/io_strobe memory-mapped output port.
interface mem_responder_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
);
  logic              CS;
  logic              R_NW;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              ready;
  logic              access_err;
`ifdef MEM_IO_PORT_EN
  logic [WORD_W-1:0] io_out;
  logic              io_strobe;
`endif
  modport master (
    output CS, R_NW, address, data_in,
    input  data_out, data_valid, ready, access_err
`ifdef MEM_IO_PORT_EN
    , input io_out, io_strobe
`endif
  );
  modport slave (
    input  CS, R_NW, address, data_in,
    output data_out, data_valid, ready, access_err
`ifdef MEM_IO_PORT_EN
    , output io_out, io_strobe
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word RAM zeroed after reset, with registered reads and a sticky early-access flag.
// MEM_IO_PORT_EN maps the all-ones address onto the io_out output port.
module mem_responder #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input logic           clock,
  input logic           n_reset,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {CLEAR, IDLE, READ} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] data_out_q;
  logic [WORD_W-1:0] rd_data;
  logic              data_valid_q;
  logic              ready_q;
  logic              err_q;
  logic              rd;
  logic              wr;
  assign rd = state_q != CLEAR && bus.CS && bus.R_NW;
  assign wr = state_q != CLEAR && bus.CS && !bus.R_NW;
`ifdef MEM_IO_PORT_EN
  logic [WORD_W-1:0] io_out_q;
  logic              io_strobe_q;
  logic              io_hit;
  assign io_hit       = bus.address == LAST;
  assign rd_data      = io_hit ? io_out_q : mem_q[bus.address];
  assign bus.io_out    = io_out_q;
  assign bus.io_strobe = io_strobe_q;
`else
  assign rd_data = mem_q[bus.address];
`endif
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.ready      = ready_q;
  assign bus.access_err = err_q;
  always_ff @(posedge clock or negedge n_reset)
    if (!n_reset) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef MEM_IO_PORT_EN
      io_out_q     <= '0;
      io_strobe_q  <= 1'b0;
`endif
    end else begin
      ptr_q        <= state_q == CLEAR ? ptr_q + 1'b1 : ptr_q;
      state_q      <= state_q == CLEAR ? (ptr_q == LAST ? IDLE : CLEAR) : (rd ? READ : IDLE);
      ready_q      <= ready_q | (state_q == CLEAR && ptr_q == LAST);
      err_q        <= err_q | (state_q == CLEAR && bus.CS);
      data_valid_q <= rd;
      data_out_q   <= rd ? rd_data : data_out_q;
`ifdef MEM_IO_PORT_EN
      io_strobe_q  <= wr && io_hit;
      io_out_q     <= wr && io_hit ? bus.data_in : io_out_q;
`endif
    end
  // Storage has no reset; the CLEAR sweep zeroes it one word per cycle.
  always_ff @(posedge clock)
    if (state_q == CLEAR) mem_q[ptr_q] <= '0;
    else if (wr) mem_q[bus.address] <= bus.data_in;
endmodule
